// File: rtl/rcb_spi_master.sv
// rcb_spi_master
// SPI master (mode 0) issuing single 48-bit read/write frames to the RCB
// register slave. Frame word, MSB first: {rw, addr[14:0], data[31:0]}, where
// rw = 1 is a read. For reads the last 32 bits clocked in on miso become rdata.
//
// Ports
//   clk_100m  in   system clock
//   rst_n     in   synchronous active-low reset
//   start     in   frame request, accepted only while idle
//   rw        in   1 = read, 0 = write (sampled with start)
//   addr      in   15-bit register address (sampled with start)
//   wdata     in   32-bit write data (sampled with start)
//   busy      out  high from the cycle after accept until the inter-frame gap ends
//   done      out  1-cycle pulse as cs_n deasserts; rdata valid in that cycle
//   rdata     out  read data from the most recent read frame
//   sclk      out  SPI clock, idles low
//   cs_n      out  SPI chip select, active low
//   mosi      out  serial data to slave
//   miso      in   serial data from slave, asynchronous
//
// State table
//   state    | meaning
//   ST_IDLE  | waiting for start, cs_n high
//   ST_SETUP | cs_n low, sclk low, first bit on mosi
//   ST_SHIFT | 48 bit periods: CLK_DIV cycles sclk low, CLK_DIV cycles sclk high
//   ST_HOLD  | sclk low after the last falling edge, cs_n still low
//   ST_GAP   | cs_n high, busy, start ignored

module rcb_spi_master #(
    parameter int unsigned CLK_DIV  = 5,
    parameter int unsigned CS_SETUP = 4,
    parameter int unsigned CS_HOLD  = 4,
    parameter int unsigned CS_GAP   = 8
) (
    input  logic        clk_100m,
    input  logic        rst_n,
    input  logic        start,
    input  logic        rw,
    input  logic [14:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        sclk,
    output logic        cs_n,
    output logic        mosi,
    input  logic        miso
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    // Down-counter reload values; each phase ends on the cycle the counter reads zero.
    localparam logic [7:0] DIV_LD   = 8'(CLK_DIV - 1);
    localparam logic [7:0] SETUP_LD = 8'(CS_SETUP - 1);
    localparam logic [7:0] HOLD_LD  = 8'(CS_HOLD - 1);
    localparam logic [7:0] GAP_LD   = 8'(CS_GAP - 1);
    localparam logic [5:0] LAST_BIT = 6'd47;

    logic [2:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [5:0]  bit_q, bit_d;
    // Bit 47 (rw) goes straight to mosi at accept, so only bits 46:0 are held.
    logic [46:0] sh_q, sh_d;
    // Only the last 32 sampled bits are ever used, so older bits fall off the top.
    logic [31:0] rx_q, rx_d;
    logic        rw_q, rw_d;
    logic        sclk_q, sclk_d;
    logic        cs_n_q, cs_n_d;
    logic        mosi_q, mosi_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] rdata_q, rdata_d;
    logic        miso_s1_q, miso_s2_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        rx_d    = rx_q;
        rw_d    = rw_q;
        sclk_d  = sclk_q;
        cs_n_d  = cs_n_q;
        mosi_d  = mosi_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SETUP;
                    cnt_d   = SETUP_LD;
                    bit_d   = 6'd0;
                    sh_d    = {addr, wdata};
                    rw_d    = rw;
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    mosi_d  = rw;
                end
            end
            ST_SETUP: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_SHIFT;
                    cnt_d   = DIV_LD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_SHIFT: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else if (!sclk_q) begin
                    sclk_d = 1'b1;
                    cnt_d  = DIV_LD;
                end else begin
                    // Last high cycle: sample the synchronised miso, then fall.
                    // The two-flop lag is hidden because miso last moved a full
                    // low phase (>= 3 cycles) earlier.
                    sclk_d = 1'b0;
                    rx_d   = {rx_q[30:0], miso_s2_q};
                    if (bit_q == LAST_BIT) begin
                        state_d = ST_HOLD;
                        cnt_d   = HOLD_LD;
                    end else begin
                        bit_d  = bit_q + 6'd1;
                        mosi_d = sh_q[46];
                        sh_d   = {sh_q[45:0], 1'b0};
                        cnt_d  = DIV_LD;
                    end
                end
            end
            ST_HOLD: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_LD;
                    cs_n_d  = 1'b1;
                    mosi_d  = 1'b0;
                    done_d  = 1'b1;
                    if (rw_q) begin
                        rdata_d = rx_q;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_GAP: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_100m) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 8'd0;
            bit_q     <= 6'd0;
            sh_q      <= '0;
            rx_q      <= '0;
            rw_q      <= 1'b0;
            sclk_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rdata_q   <= '0;
            miso_s1_q <= 1'b0;
            miso_s2_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            sh_q      <= sh_d;
            rx_q      <= rx_d;
            rw_q      <= rw_d;
            sclk_q    <= sclk_d;
            cs_n_q    <= cs_n_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rdata_q   <= rdata_d;
            miso_s1_q <= miso;
            miso_s2_q <= miso_s1_q;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign rdata = rdata_q;
    assign sclk  = sclk_q;
    assign cs_n  = cs_n_q;
    assign mosi  = mosi_q;

endmodule

// File: tb/tb_rcb_spi_master.sv
// Bench for rcb_spi_master: two instances (CLK_DIV 5 and 3) with a mode-0 SPI
// slave model each. Stimulus pushes the expected frame (mosi word, rdata) into a
// per-instance queue; a monitor reconstructs each frame from the pins and
// compares when done pulses.

module tb_rcb_spi_master;

    localparam int CS_SETUP = 4;
    localparam int CS_HOLD  = 4;
    localparam int CS_GAP   = 8;

    typedef struct packed {
        logic [47:0] mosi;
        logic [31:0] rdata;
    } exp_t;

    logic clk_100m = 1'b0;
    always #5 clk_100m = ~clk_100m;

    logic        rst_n = 1'b0;
    logic        start_a [2];
    logic        rw_a    [2];
    logic [14:0] addr_a  [2];
    logic [31:0] wdata_a [2];
    logic        busy_a  [2];
    logic        done_a  [2];
    logic [31:0] rdata_a [2];
    logic        sclk_a  [2];
    logic        cs_n_a  [2];
    logic        mosi_a  [2];
    logic        miso_a  [2];

    exp_t        exp_q [2][$];
    logic [47:0] slv_word    [2];
    logic [31:0] model_rdata [2];
    int          done_cnt    [2];
    int          last_gap    [2];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk_100m) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int D = (g == 0) ? 5 : 3;

        rcb_spi_master #(
            .CLK_DIV (D),
            .CS_SETUP(CS_SETUP),
            .CS_HOLD (CS_HOLD),
            .CS_GAP  (CS_GAP)
        ) u_dut (
            .clk_100m(clk_100m),
            .rst_n   (rst_n),
            .start   (start_a[g]),
            .rw      (rw_a[g]),
            .addr    (addr_a[g]),
            .wdata   (wdata_a[g]),
            .busy    (busy_a[g]),
            .done    (done_a[g]),
            .rdata   (rdata_a[g]),
            .sclk    (sclk_a[g]),
            .cs_n    (cs_n_a[g]),
            .mosi    (mosi_a[g]),
            .miso    (miso_a[g])
        );

        // Slave: presents bit 47 when selected, next bit after each sclk fall.
        int          falls = 0;
        logic [47:0] slv_sh;
        always @(posedge cs_n_a[g] or negedge sclk_a[g]) begin
            if (cs_n_a[g]) falls = 0;
            else           falls = falls + 1;
        end
        assign slv_sh    = slv_word[g] << falls;
        assign miso_a[g] = slv_sh[47];

        logic        prev_sclk = 1'b0;
        logic        prev_cs   = 1'b1;
        int          rises = 0, cs_fall_cyc = 0, cs_rise_cyc = 0;
        int          last_rise = -1, period_bad = 0, idle_tog = 0;
        logic [47:0] mosi_cap = '0;
        exp_t        e;

        always @(negedge clk_100m) begin
            if (!rst_n) begin
                prev_sclk = 1'b0;
                prev_cs   = 1'b1;
            end else begin
                if (prev_cs && !cs_n_a[g]) begin
                    rises       = 0;
                    mosi_cap    = '0;
                    last_rise   = -1;
                    period_bad  = 0;
                    cs_fall_cyc = cyc;
                    last_gap[g] = cyc - cs_rise_cyc;
                end
                if (!prev_cs && cs_n_a[g]) cs_rise_cyc = cyc;
                if (sclk_a[g] && cs_n_a[g]) idle_tog++;
                if (!prev_sclk && sclk_a[g]) begin
                    rises++;
                    mosi_cap = {mosi_cap[46:0], mosi_a[g]};
                    if (last_rise >= 0 && (cyc - last_rise) != 2 * D) period_bad++;
                    last_rise = cyc;
                end
                if (done_a[g]) begin
                    done_cnt[g]++;
                    check("done_expected", 64'(exp_q[g].size() > 0), 64'(1));
                    if (exp_q[g].size() > 0) begin
                        e = exp_q[g].pop_front();
                        check("mosi_word", 64'(mosi_cap), 64'(e.mosi));
                        check("sclk_rises", 64'(rises), 64'(48));
                        check("rdata", 64'(rdata_a[g]), 64'(e.rdata));
                        // cs_n falls one cycle after accept.
                        check("frame_len", 64'(cyc - cs_fall_cyc + 1),
                              64'(1 + CS_SETUP + 96 * D + CS_HOLD));
                        check("sclk_period", 64'(period_bad), 64'(0));
                        check("sclk_while_cs_high", 64'(idle_tog), 64'(0));
                        check("done_cs_busy_mosi", 64'({cs_n_a[g], busy_a[g], mosi_a[g]}), 64'(3'b110));
                    end
                end
                prev_sclk = sclk_a[g];
                prev_cs   = cs_n_a[g];
            end
        end
    end

    task automatic tick();
        @(negedge clk_100m);
    endtask

    task automatic push_frame(input int g, input logic rw, input logic [14:0] a, input logic [31:0] wd);
        exp_t e;
        e.mosi  = {rw, a, wd};
        e.rdata = rw ? slv_word[g][31:0] : model_rdata[g];
        model_rdata[g] = e.rdata;
        exp_q[g].push_back(e);
    endtask

    task automatic wait_idle(input int g);
        int n = 0;
        while (busy_a[g] && n < 3000) begin tick(); n++; end
        if (busy_a[g]) check("idle_timeout", 64'(busy_a[g]), 64'(0));
    endtask

    task automatic wait_dones(input int g, input int target);
        int n = 0;
        while (done_cnt[g] < target && n < 3000) begin tick(); n++; end
        if (done_cnt[g] < target) check("done_timeout", 64'(done_cnt[g]), 64'(target));
    endtask

    task automatic wait_rises(input int g, input int k);
        int n = 0, r = 0;
        logic p = sclk_a[g];
        while (r < k && n < 3000) begin
            tick(); n++;
            if (!p && sclk_a[g]) r++;
            p = sclk_a[g];
        end
        if (r < k) check("rise_timeout", 64'(r), 64'(k));
    endtask

    task automatic issue(input int g, input logic rw, input logic [14:0] a, input logic [31:0] wd);
        start_a[g] = 1'b1; rw_a[g] = rw; addr_a[g] = a; wdata_a[g] = wd;
        push_frame(g, rw, a, wd);
        tick();
        start_a[g] = 1'b0; rw_a[g] = ~rw; addr_a[g] = 15'($urandom); wdata_a[g] = $urandom;
        check("busy_after_accept", 64'(busy_a[g]), 64'(1));
        check("cs_low_after_accept", 64'(cs_n_a[g]), 64'(0));
    endtask

    task automatic frame(input int g, input logic rw, input logic [14:0] a,
                         input logic [31:0] wd, input logic [31:0] sd);
        int target;
        wait_idle(g);
        slv_word[g] = {16'($urandom), sd};
        target = done_cnt[g] + 1;
        issue(g, rw, a, wd);
        wait_dones(g, target);
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        for (int g = 0; g < 2; g++) begin
            start_a[g] = 1'b0; rw_a[g] = 1'b0; addr_a[g] = '0; wdata_a[g] = '0;
            slv_word[g] = '0; model_rdata[g] = '0; done_cnt[g] = 0; last_gap[g] = 0;
        end
        tick(); tick();
        for (int g = 0; g < 2; g++)
            check("reset_outputs", 64'({cs_n_a[g], sclk_a[g], mosi_a[g], busy_a[g], done_a[g], rdata_a[g]}),
                  64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0}));
        rst_n = 1'b1;
        tick(); tick();

        // T1 write, T2 read
        frame(0, 1'b0, 15'h0012, 32'hDEADBEEF, 32'h13572468);
        frame(0, 1'b1, 15'h0034, 32'h01234567, 32'hA5A55A5A);

        // T3 start pulses during SHIFT and GAP are ignored
        wait_idle(0);
        dc = done_cnt[0];
        slv_word[0] = {16'h0, 32'h0};
        issue(0, 1'b0, 15'h0101, 32'h55AA00FF);
        wait_rises(0, 10);
        start_a[0] = 1'b1; tick(); start_a[0] = 1'b0;
        wait_dones(0, dc + 1);
        tick();
        start_a[0] = 1'b1; tick(); start_a[0] = 1'b0;
        repeat (700) tick();
        check("t3_done_count", 64'(done_cnt[0] - dc), 64'(1));
        check("t3_idle", 64'(busy_a[0]), 64'(0));

        // T4 reset mid-frame (rdata currently 0xA5A55A5A)
        wait_idle(0);
        dc = done_cnt[0];
        slv_word[0] = {16'hFFFF, 32'hFFFFFFFF};
        issue(0, 1'b1, 15'h0777, 32'h0);
        wait_rises(0, 20);
        rst_n = 1'b0;
        tick();
        check("t4_reset_outputs", 64'({cs_n_a[0], sclk_a[0], mosi_a[0], busy_a[0], done_a[0], rdata_a[0]}),
              64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0}));
        exp_q[0].delete();
        exp_q[1].delete();
        model_rdata[0] = '0;
        model_rdata[1] = '0;
        tick();
        rst_n = 1'b1;
        repeat (600) tick();
        check("t4_no_done", 64'(done_cnt[0] - dc), 64'(0));
        frame(0, 1'b1, 15'h7FFF, 32'h0, 32'h0F1E2D3C);

        // T5 back-to-back with start held
        wait_idle(0);
        dc = done_cnt[0];
        start_a[0] = 1'b1; rw_a[0] = 1'b0; addr_a[0] = 15'h2A5C; wdata_a[0] = 32'hC0FFEE11;
        push_frame(0, 1'b0, 15'h2A5C, 32'hC0FFEE11);
        push_frame(0, 1'b0, 15'h2A5C, 32'hC0FFEE11);
        wait_dones(0, dc + 1);
        begin
            int n = 0;
            while (cs_n_a[0] && n < 100) begin tick(); n++; end
        end
        start_a[0] = 1'b0;
        check("t5_gap_cycles", 64'(last_gap[0]), 64'(CS_GAP + 1));
        wait_dones(0, dc + 2);

        // T6 CLK_DIV=3 read, plus random traffic on both instances
        frame(1, 1'b1, 15'h0042, 32'h0, 32'h3C3CC3C3);
        for (int i = 0; i < 6; i++) begin
            frame(0, 1'($urandom), 15'($urandom), $urandom, $urandom);
            frame(1, 1'($urandom), 15'($urandom), $urandom, $urandom);
        end

        repeat (20) tick();
        check("queue0_drained", 64'(exp_q[0].size()), 64'(0));
        check("queue1_drained", 64'(exp_q[1].size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
